// File: rtl/draw_pkg.sv
// Shared definitions for the VGA draw chain: highlight modes, colour constants,
// default board geometry and the pixel bus carried between painter stages.
package draw_pkg;

    typedef enum logic [1:0] {
        HL_OFF    = 2'd0,
        HL_SOLID  = 2'd1,
        HL_BLINK  = 2'd2,
        HL_BORDER = 2'd3
    } hl_mode_e;

    localparam logic [11:0] COLOR_BLACK     = 12'h000;
    localparam logic [11:0] COLOR_WHITE     = 12'hfff;
    localparam logic [11:0] COLOR_RED       = 12'hf00;
    localparam logic [11:0] COLOR_BLUE      = 12'h00f;
    localparam logic [11:0] COLOR_YELLOW    = 12'hff0;
    localparam logic [11:0] COLOR_HIGHLIGHT = COLOR_YELLOW;

    localparam int BOARD_GRID_N   = 3;
    localparam int BOARD_ORIGIN_X = 90;
    localparam int BOARD_ORIGIN_Y = 10;
    localparam int BOARD_CELL_W   = 249;
    localparam int BOARD_CELL_H   = 249;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

    // Pixel coordinate of edge number idx along one axis, in 12 bits so it never wraps.
    function automatic logic [11:0] cell_edge(input int origin, input int size, input int idx);
        return 12'(origin + idx * size);
    endfunction

endpackage

// File: rtl/vga_frame_timer.sv
// Frame-rate timebase: vblank rising-edge detect, a one-cycle frame tick and a
// blink phase that toggles every BLINK_FRAMES frames.
module vga_frame_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic pclk,
    input  logic rst,
    input  logic vblnk_in,
    input  logic clear,
    output logic vblnk_rise,
    output logic frame_tick,
    output logic blink_phase
);

    localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             vblnk_prev_q, vblnk_prev_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    assign vblnk_rise = vblnk_in & ~vblnk_prev_q;

    always_comb begin
        vblnk_prev_d = vblnk_in;
        tick_d       = vblnk_rise;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (vblnk_rise) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The previous-vblank copy resets high so a reset released inside vblank
    // does not fake an edge.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vblnk_prev_q <= 1'b1;
            tick_q       <= 1'b0;
            cnt_q        <= '0;
            phase_q      <= 1'b1;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            tick_q       <= tick_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign frame_tick  = tick_q;
    assign blink_phase = phase_q;

endmodule

// File: rtl/draw_cell_highlight.sv
// Draw-chain stage that paints one run-time selected cell of the game board in
// solid, blinking or border-only style, with a fixed two-cycle latency.
module draw_cell_highlight
    import draw_pkg::*;
#(
    parameter int          GRID_N       = BOARD_GRID_N,
    parameter int          ORIGIN_X     = BOARD_ORIGIN_X,
    parameter int          ORIGIN_Y     = BOARD_ORIGIN_Y,
    parameter int          CELL_W       = BOARD_CELL_W,
    parameter int          CELL_H       = BOARD_CELL_H,
    parameter int          BORDER_W     = 8,
    parameter logic [11:0] HL_COLOR     = COLOR_HIGHLIGHT,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        start_en,
    input  logic [3:0]  cell_sel,
    input  logic [1:0]  mode,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        frame_tick
);

    localparam int N_CELLS = GRID_N * GRID_N;

    logic        vblnk_rise;
    logic        blink_phase;
    logic        blink_clear;
    hl_mode_e    mode_in;

    logic        en_q, en_d;
    logic [3:0]  sel_q, sel_d;
    hl_mode_e    mode_q, mode_d;

    vga_bus_t    bus_in;
    vga_bus_t    s1_bus_q, s1_bus_d;
    vga_bus_t    s2_bus_q, s2_bus_d;
    logic        in_cell_q, in_cell_d;
    logic        in_border_q, in_border_d;

    logic [11:0] hpos, vpos;
    logic [GRID_N-1:0]  col_hit, col_edge, row_hit, row_edge;
    logic [N_CELLS-1:0] cell_match, cell_edge_hit;
    logic        sel_valid;
    logic        paint;

    assign mode_in = hl_mode_e'(mode);
    assign hpos    = {1'b0, hcount_in};
    assign vpos    = {1'b0, vcount_in};

    assign bus_in = '{hcount: hcount_in, vcount: vcount_in,
                      hsync:  hsync_in,  vsync:  vsync_in,
                      hblnk:  hblnk_in,  vblnk:  vblnk_in,
                      rgb:    rgb_in};

    vga_frame_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_frame_timer (
        .pclk        (pclk),
        .rst         (rst),
        .vblnk_in    (vblnk_in),
        .clear       (blink_clear),
        .vblnk_rise  (vblnk_rise),
        .frame_tick  (frame_tick),
        .blink_phase (blink_phase)
    );

    // Entering BLINK restarts the blink so the first frame is always visible.
    assign blink_clear = vblnk_rise && (mode_in == HL_BLINK) && (mode_q != HL_BLINK);

    always_comb begin
        en_d   = en_q;
        sel_d  = sel_q;
        mode_d = mode_q;
        if (vblnk_rise) begin
            en_d   = start_en;
            sel_d  = cell_sel;
            mode_d = mode_in;
        end
    end

    for (genvar i = 0; i < GRID_N; i++) begin : g_axis
        localparam logic [11:0] X_LO   = cell_edge(ORIGIN_X, CELL_W, i);
        localparam logic [11:0] X_HI   = cell_edge(ORIGIN_X, CELL_W, i + 1);
        localparam logic [11:0] X_LO_B = cell_edge(ORIGIN_X + BORDER_W, CELL_W, i);
        localparam logic [11:0] X_HI_B = cell_edge(ORIGIN_X - BORDER_W, CELL_W, i + 1);
        localparam logic [11:0] Y_LO   = cell_edge(ORIGIN_Y, CELL_H, i);
        localparam logic [11:0] Y_HI   = cell_edge(ORIGIN_Y, CELL_H, i + 1);
        localparam logic [11:0] Y_LO_B = cell_edge(ORIGIN_Y + BORDER_W, CELL_H, i);
        localparam logic [11:0] Y_HI_B = cell_edge(ORIGIN_Y - BORDER_W, CELL_H, i + 1);

        assign col_hit[i]  = (hpos >= X_LO) && (hpos < X_HI);
        assign col_edge[i] = (hpos < X_LO_B) || (hpos >= X_HI_B);
        assign row_hit[i]  = (vpos >= Y_LO) && (vpos < Y_HI);
        assign row_edge[i] = (vpos < Y_LO_B) || (vpos >= Y_HI_B);
    end

    for (genvar r = 0; r < GRID_N; r++) begin : g_row
        for (genvar c = 0; c < GRID_N; c++) begin : g_col
            localparam int IDX = r * GRID_N + c;
            assign cell_match[IDX]    = row_hit[r] & col_hit[c] & (sel_q == 4'(IDX));
            assign cell_edge_hit[IDX] = row_edge[r] | col_edge[c];
        end
    end

    assign sel_valid = ({1'b0, sel_q} < 5'(N_CELLS));

    always_comb begin
        s1_bus_d    = bus_in;
        in_cell_d   = sel_valid & (|cell_match);
        in_border_d = |(cell_match & cell_edge_hit);
    end

    always_comb begin
        paint = 1'b0;
        if (en_q && sel_valid) begin
            case (mode_q)
                HL_SOLID:  paint = in_cell_q;
                HL_BLINK:  paint = in_cell_q & blink_phase;
                HL_BORDER: paint = in_cell_q & in_border_q;
                default:   paint = 1'b0;
            endcase
        end
    end

    always_comb begin
        s2_bus_d = s1_bus_q;
        if (paint && !(s1_bus_q.hblnk || s1_bus_q.vblnk)) begin
            s2_bus_d.rgb = HL_COLOR;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            en_q        <= 1'b0;
            sel_q       <= '0;
            mode_q      <= HL_OFF;
            s1_bus_q    <= '0;
            in_cell_q   <= 1'b0;
            in_border_q <= 1'b0;
            s2_bus_q    <= '0;
        end else begin
            en_q        <= en_d;
            sel_q       <= sel_d;
            mode_q      <= mode_d;
            s1_bus_q    <= s1_bus_d;
            in_cell_q   <= in_cell_d;
            in_border_q <= in_border_d;
            s2_bus_q    <= s2_bus_d;
        end
    end

    assign hcount_out = s2_bus_q.hcount;
    assign vcount_out = s2_bus_q.vcount;
    assign hsync_out  = s2_bus_q.hsync;
    assign vsync_out  = s2_bus_q.vsync;
    assign hblnk_out  = s2_bus_q.hblnk;
    assign vblnk_out  = s2_bus_q.vblnk;
    assign rgb_out    = s2_bus_q.rgb;

endmodule

// File: tb/tb_draw_cell_highlight.sv
// Directed bench for draw_cell_highlight: a scoreboard of expected output pixels
// (two-cycle latency) plus frame_tick, reset and blink checks.
module tb_draw_cell_highlight;

    localparam logic [11:0] HL = 12'hff0;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    logic        pclk, rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic        start_en;
    logic [3:0]  cell_sel;
    logic [1:0]  mode;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        frame_tick;

    pix_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ticks = 0;
    logic tick_exp = 1'b0;
    logic prev_vb_drv = 1'b0;

    logic       m_en = 1'b0;
    logic [3:0] m_sel = 4'd0;
    logic [1:0] m_mode = 2'd0;
    logic       m_phase = 1'b1;

    draw_cell_highlight #(
        .BLINK_FRAMES (2)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .start_en   (start_en),
        .cell_sel   (cell_sel),
        .mode       (mode),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .frame_tick (frame_tick)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Reference painter for the default 3x3 board at origin (90,10), 249-pixel cells.
    function automatic logic [11:0] model_rgb(input int h, input int v, input logic hb,
                                              input logic vb, input logic [11:0] rgb);
        int col, row, dx, dy;
        if (hb || vb || !m_en || m_mode == 2'd0 || m_sel >= 4'd9) return rgb;
        if (h < 90 || h >= 837 || v < 10 || v >= 757) return rgb;
        col = (h - 90) / 249;
        row = (v - 10) / 249;
        dx  = (h - 90) % 249;
        dy  = (v - 10) % 249;
        if (row * 3 + col != int'(m_sel)) return rgb;
        case (m_mode)
            2'd1:    return HL;
            2'd2:    return m_phase ? HL : rgb;
            default: return (dx < 8 || dx >= 241 || dy < 8 || dy >= 241) ? HL : rgb;
        endcase
    endfunction

    function automatic pix_t heldExpect();
        pix_t e;
        e.h   = hcount_in;
        e.v   = vcount_in;
        e.hs  = hsync_in;
        e.vs  = vsync_in;
        e.hb  = hblnk_in;
        e.vb  = vblnk_in;
        e.rgb = model_rgb(int'(hcount_in), int'(vcount_in), hblnk_in, vblnk_in, rgb_in);
        return e;
    endfunction

    task automatic checkZero(input string tag);
        logic [38:0] obs;
        obs = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, frame_tick};
        n_cmp++;
        assert (obs === 39'd0) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=0", tag, obs);
        end
    endtask

    task automatic checkOutput();
        pix_t o, e;
        o = '{h: hcount_out, v: vcount_out, hs: hsync_out, vs: vsync_out,
              hb: hblnk_out, vb: vblnk_out, rgb: rgb_out};
        if (frame_tick === 1'b1) ticks++;
        n_cmp++;
        assert (frame_tick === tick_exp) else begin
            n_fail++;
            $error("[TB] FAIL frame_tick observed=%b expected=%b", frame_tick, tick_exp);
        end
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            n_cmp++;
            assert (o === e) else begin
                n_fail++;
                $error("[TB] FAIL pixel(%0d,%0d) observed rgb=%h bus=%h expected rgb=%h bus=%h",
                       e.h, e.v, o.rgb, o, e.rgb, e);
            end
        end
    endtask

    task automatic applyStimulus(input int h, input int v, input logic hb, input logic vb);
        logic [10:0] hh, vv;
        pix_t e;
        hh = 11'(h);
        vv = 11'(v);
        @(negedge pclk);
        checkOutput();
        hcount_in = hh;
        vcount_in = vv;
        hsync_in  = hh[1];
        vsync_in  = vv[2];
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = 12'((h * 7 + v * 3) & 'h7ff);
        if (vb && !prev_vb_drv) begin
            m_en   = start_en;
            m_sel  = cell_sel;
            m_mode = mode;
        end
        tick_exp    = vb && !prev_vb_drv;
        prev_vb_drv = vb;
        e = heldExpect();
        sb.push_back(e);
    endtask

    task automatic newFrame();
        applyStimulus(1024, 768, 1'b1, 1'b1);
        applyStimulus(1100, 800, 1'b1, 1'b1);
        applyStimulus(1300, 805, 1'b1, 1'b0);
    endtask

    task automatic releaseReset();
        @(negedge pclk);
        rst = 1'b0;
        checkZero("release_state");
        sb.delete();
        m_en        = 1'b0;
        m_sel       = 4'd0;
        m_mode      = 2'd0;
        m_phase     = 1'b1;
        tick_exp    = 1'b0;
        prev_vb_drv = vblnk_in;
        sb.push_back('0);
        sb.push_back(heldExpect());
    endtask

    initial begin
        logic [7:0] blink_pat;
        blink_pat = 8'b0011_0011;

        rst = 1'b1;
        hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
        start_en = 1'b0; cell_sel = '0; mode = 2'd0;

        @(negedge pclk);
        checkZero("reset_idle");
        vblnk_in = 1'b1; hcount_in = 11'd5; rgb_in = 12'h7ab;
        @(negedge pclk);
        checkZero("reset_vblnk");
        vblnk_in = 1'b0;
        @(negedge pclk);
        checkZero("reset_hold");
        releaseReset();

        // Highlight requested but not yet latched: must pass through.
        start_en = 1'b1; mode = 2'd1; cell_sel = 4'd3;
        applyStimulus(90, 259, 1'b0, 1'b0);
        applyStimulus(200, 300, 1'b0, 1'b0);

        $display("[TB] SOLID sel=3");
        newFrame();
        applyStimulus(90, 259, 1'b0, 1'b0);
        applyStimulus(338, 507, 1'b0, 1'b0);
        applyStimulus(339, 259, 1'b0, 1'b0);
        applyStimulus(90, 508, 1'b0, 1'b0);
        applyStimulus(89, 259, 1'b0, 1'b0);
        applyStimulus(90, 258, 1'b0, 1'b0);
        applyStimulus(100, 300, 1'b1, 1'b0);

        $display("[TB] BORDER sel=4");
        mode = 2'd3; cell_sel = 4'd4;
        newFrame();
        applyStimulus(346, 300, 1'b0, 1'b0);
        applyStimulus(347, 300, 1'b0, 1'b0);
        applyStimulus(587, 400, 1'b0, 1'b0);
        applyStimulus(463, 383, 1'b0, 1'b0);
        applyStimulus(339, 259, 1'b0, 1'b0);
        applyStimulus(463, 507, 1'b0, 1'b0);
        applyStimulus(588, 400, 1'b0, 1'b0);

        $display("[TB] out of range and disabled");
        mode = 2'd1; cell_sel = 4'd9;
        newFrame();
        for (int i = 0; i < 9; i++) applyStimulus(210 + 249 * (i % 3), 130 + 249 * (i / 3), 1'b0, 1'b0);
        start_en = 1'b0; cell_sel = 4'd3;
        newFrame();
        applyStimulus(90, 259, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(210 + 249 * (i % 3), 130 + 249 * (i / 3), 1'b0, 1'b0);

        $display("[TB] BLINK sel=0");
        start_en = 1'b1; mode = 2'd2; cell_sel = 4'd0;
        for (int f = 0; f < 8; f++) begin
            if (f == 6) cell_sel = 4'd1;
            ticks = 0;
            newFrame();
            m_phase = blink_pat[f];
            applyStimulus(100, 20, 1'b0, 1'b0);
            applyStimulus(338, 258, 1'b0, 1'b0);
            applyStimulus(339, 20, 1'b0, 1'b0);
            applyStimulus(400, 100, 1'b0, 1'b0);
            applyStimulus(89, 20, 1'b0, 1'b0);
            n_cmp++;
            assert (ticks == 1) else begin
                n_fail++;
                $error("[TB] FAIL ticks_per_frame frame=%0d observed=%0d expected=1", f, ticks);
            end
        end

        $display("[TB] mid-frame select change");
        mode = 2'd1; cell_sel = 4'd0;
        newFrame();
        applyStimulus(100, 50, 1'b0, 1'b0);
        applyStimulus(300, 99, 1'b0, 1'b0);
        cell_sel = 4'd8;
        applyStimulus(100, 100, 1'b0, 1'b0);
        applyStimulus(100, 150, 1'b0, 1'b0);
        applyStimulus(600, 600, 1'b0, 1'b0);
        newFrame();
        applyStimulus(100, 150, 1'b0, 1'b0);
        applyStimulus(588, 508, 1'b0, 1'b0);
        applyStimulus(836, 756, 1'b0, 1'b0);
        applyStimulus(837, 756, 1'b0, 1'b0);
        applyStimulus(588, 757, 1'b0, 1'b0);
        applyStimulus(587, 600, 1'b0, 1'b0);
        applyStimulus(600, 600, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(610, 610, 1'b0, 1'b0);
        applyStimulus(620, 620, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1 checkZero("async_reset");
        @(negedge pclk);
        checkZero("async_reset_hold");
        releaseReset();
        applyStimulus(600, 600, 1'b0, 1'b0);
        applyStimulus(700, 700, 1'b0, 1'b0);
        applyStimulus(710, 710, 1'b0, 1'b0);
        newFrame();
        applyStimulus(600, 600, 1'b0, 1'b0);
        applyStimulus(700, 700, 1'b0, 1'b0);
        applyStimulus(100, 100, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b1, 1'b0);
        applyStimulus(1, 0, 1'b1, 1'b0);
        applyStimulus(2, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
